// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared types and constants for the UART receive front end
// Contents:
//   UART_DATA_W  width of one received character
//   rx_state_t   receiver FSM state encoding
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - first-word-fall-through synchronous FIFO
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write request; push_data is the word to store
//   pop          read request; ignored while empty
//   head         word at the read pointer, zero while empty
//   empty        no words held
//   count        number of words held (0..2**AW)
//   push_drop    registered pulse: a push was refused because the FIFO was full
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          push_drop
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (MSBs equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  assign count = wr_ptr - rd_ptr;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      push_drop <= 1'b0;
    end else begin
      push_drop <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with FIFO buffering and error pulses
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   rxd          raw asynchronous serial input, idle high
//   rx_data      byte at FIFO head (zero when empty)
//   rx_valid     FIFO not empty
//   rx_ready     consumer accepts head; pop on rx_valid && rx_ready
//   rx_count     bytes held
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: good byte dropped, FIFO full
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [FIFO_AW:0]       rx_count,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int            BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BCNT_ONE = BW'(1);
  localparam logic [BW-1:0] BCNT_MID = BW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] BCNT_END = BW'(CLKS_PER_BIT - 1);

  logic                   sync1, rxs;
  rx_state_t              state, state_n;
  logic [BW-1:0]          bcnt, bcnt_n;
  logic [2:0]             bidx, bidx_n;
  logic [UART_DATA_W-1:0] shift, shift_n;
  logic                   armed, armed_n;
  logic                   ferr_n;
  logic                   push;
  logic                   fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      bcnt      <= '0;
      bidx      <= '0;
      shift     <= '0;
      armed     <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rxd;
      rxs       <= sync1;
      state     <= state_n;
      bcnt      <= bcnt_n;
      bidx      <= bidx_n;
      shift     <= shift_n;
      armed     <= armed_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    bidx_n  = bidx;
    shift_n = shift;
    armed_n = armed;
    ferr_n  = 1'b0;
    push    = 1'b0;
    case (state)
      IDLE: begin
        // After a framing error the line must return high before a new
        // falling edge counts, so a held break reports only once.
        if (!armed) begin
          armed_n = rxs;
        end else if (!rxs) begin
          state_n = START;
          bcnt_n  = '0;
        end
      end
      START: begin
        if (bcnt == BCNT_MID) begin
          bcnt_n = '0;
          if (!rxs) begin
            state_n = DATA;
            bidx_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bcnt_n = bcnt + BCNT_ONE;
        end
      end
      DATA: begin
        if (bcnt == BCNT_END) begin
          shift_n[bidx] = rxs;
          bcnt_n        = '0;
          bidx_n        = bidx + 3'd1;
          if (bidx == 3'd7) state_n = STOP;
        end else begin
          bcnt_n = bcnt + BCNT_ONE;
        end
      end
      STOP: begin
        if (bcnt == BCNT_END) begin
          state_n = IDLE;
          bcnt_n  = '0;
          if (rxs) begin
            push = 1'b1;
          end else begin
            ferr_n  = 1'b1;
            armed_n = 1'b0;
          end
        end else begin
          bcnt_n = bcnt + BCNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  sync_fifo #(
    .DW (UART_DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift),
    .pop       (rx_ready),
    .head      (rx_data),
    .empty     (fifo_empty),
    .count     (rx_count),
    .push_drop (overrun)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  // Cycles from the start edge to the stop sample: 2 sync flops, 1 idle
  // detect, half a bit to mid-start, then 8 data bits plus the stop bit.
  localparam int LAT   = 3 + CPB/2 + 9*CPB;
  localparam int FERR  = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW:0]   rx_count;
  logic          frame_err;
  logic          overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int         cyc = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] q[$];
  int         sched[int];
  bit         exp_ferr = 1'b0;
  bit         exp_ovr = 1'b0;
  int         ferr_seen = 0;
  int         ovr_seen = 0;
  int         last_start = 0;
  int         rise_cyc = 0;
  bit         prev_valid = 1'b0;
  logic [7:0] popped[$];
  bit         rand_done;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
  endtask

  // Reference model: a byte queue that pops when non-empty and ready, then
  // applies whatever frame outcome lands on this cycle.
  always @(posedge clk) begin
    cyc++;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (rst_n) begin
      if (rx_ready && q.size() > 0) void'(q.pop_front());
      if (sched.exists(cyc)) begin
        if (sched[cyc] == FERR)   exp_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(8'(sched[cyc]));
        else                       exp_ovr = 1'b1;
        sched.delete(cyc);
      end
    end
  end

  always @(negedge clk) begin
    chk("rx_valid",  int'(rx_valid),  (q.size() > 0) ? 1 : 0);
    chk("rx_data",   int'(rx_data),   (q.size() > 0) ? int'(q[0]) : 0);
    chk("rx_count",  int'(rx_count),  q.size());
    chk("frame_err", int'(frame_err), int'(exp_ferr));
    chk("overrun",   int'(overrun),   int'(exp_ovr));
    if (frame_err) ferr_seen++;
    if (overrun)   ovr_seen++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) popped.push_back(rx_data);
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] bits;
    bits       = {stop, b, 1'b0};
    last_start = cyc;
    sched[cyc + LAT] = stop ? int'(b) : FERR;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    step(n);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    idle(2*DEPTH + 2);
    rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  f0;
    int  o0;
    bit  st;
    int  ready_div;

    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    step(1);
    chk("reset rx_valid", int'(rx_valid), 0);
    chk("reset rx_data",  int'(rx_data),  0);
    step(2);
    rst_n = 1'b1;
    idle(4);

    // Single byte, consumer stalled.
    f0 = ferr_seen; o0 = ovr_seen;
    send_frame(8'hA5, 1'b1);
    idle(8);
    chk("a5 latency",  rise_cyc - last_start, 41);
    chk("a5 rx_data",  int'(rx_data), 8'hA5);
    chk("a5 rx_count", int'(rx_count), 1);
    chk("a5 no errors", (ferr_seen - f0) + (ovr_seen - o0), 0);
    drain();

    // Back-to-back frames drained in order.
    popped.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(4);
    rx_ready = 1'b1;
    idle(6);
    rx_ready = 1'b0;
    chk("b2b pop count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("b2b pop0", int'(popped[0]), 8'h00);
      chk("b2b pop1", int'(popped[1]), 8'hFF);
      chk("b2b pop2", int'(popped[2]), 8'h3C);
    end
    chk("b2b empty valid", int'(rx_valid), 0);
    chk("b2b empty data",  int'(rx_data),  0);

    // Overflow: fifth byte dropped with one overrun pulse.
    o0 = ovr_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(4);
    chk("ovf rx_count", int'(rx_count), 4);
    chk("ovf pulses", ovr_seen - o0, 1);
    popped.delete();
    drain();
    chk("ovf pop count", popped.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk("ovf pop data", int'(popped[i]), i + 1);

    // Framing error followed by a long break, then a clean byte.
    f0 = ferr_seen;
    send_frame(8'h55, 1'b0);
    rxd = 1'b0;
    step(20*CPB);
    idle(CPB);
    send_frame(8'h77, 1'b1);
    idle(8);
    chk("break ferr pulses", ferr_seen - f0, 1);
    chk("break rx_count", int'(rx_count), 1);
    chk("break rx_data",  int'(rx_data), 8'h77);
    drain();

    // One-cycle glitch while idle.
    f0 = ferr_seen;
    rxd = 1'b0;
    step(1);
    idle(4*CPB);
    chk("glitch rx_count", int'(rx_count), 0);
    chk("glitch ferr", ferr_seen - f0, 0);
    send_frame(8'h42, 1'b1);
    idle(8);
    chk("post glitch data", int'(rx_data), 8'h42);
    drain();

    // Reset in the middle of DATA with bytes queued.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rxd = 1'b0; step(CPB);
    rxd = 1'b1; step(CPB);
    rxd = 1'b0; step(CPB);
    chk("pre reset count", int'(rx_count), 2);
    rst_n = 1'b0;
    q.delete();
    sched.delete();
    rxd = 1'b1;
    #1;
    chk("mid reset valid", int'(rx_valid), 0);
    chk("mid reset count", int'(rx_count), 0);
    step(2);
    rst_n = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b1);
    idle(8);
    chk("post reset data",  int'(rx_data), 8'h81);
    chk("post reset count", int'(rx_count), 1);
    drain();

    // Randomised traffic: slow consumer first to force overruns, then fast.
    rand_done = 1'b0;
    ready_div = 80;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if (k == 20) ready_div = 3;
          st = ($urandom_range(0, 5) != 0);
          send_frame(8'($urandom), st);
          idle(st ? int'($urandom_range(0, 6)) : CPB + int'($urandom_range(0, 4)));
        end
        idle(LAT);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          rx_ready = ($urandom_range(0, ready_div - 1) == 0);
        end
      end
    join
    drain();
    chk("final empty", int'(rx_valid), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
